// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: PC-register link, instruction-memory handshake
// and the instruction buffer head presented to decode.
interface if_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] curPC;
    logic              PCWre;
    logic              flush;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              inst_valid;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport slave (
        input  curPC, flush, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        output PCWre, imem_req, imem_addr, inst_valid, inst, inst_pc
    );

    modport master (
        output curPC, flush, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        input  PCWre, imem_req, imem_addr, inst_valid, inst, inst_pc
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: one outstanding imem request at a time, PC advance via
// PCWre on grant, registered instruction FIFO toward decode, flush on redirect.
module if_fetch_unit #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input logic           CLK,
    input logic           Reset,
    if_fetch_unit_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_count, w_cnt_next;
    logic [PTR_W-1:0]  r_rd, r_wr;
    logic [ADDR_W-1:0] r_req_pc;
    logic [DATA_W-1:0] r_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_pc   [FIFO_DEPTH];
    logic              w_valid, w_push, w_pop, w_req, w_pcwre, w_room;

    // flush wins over any same-cycle push or pop
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid & bus.inst_ready & ~bus.flush;
    assign w_push     = (r_state == WAIT) & bus.imem_rvalid & ~bus.flush;
    assign w_cnt_next = bus.flush ? '0 : r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_room     = (w_cnt_next < DEPTH_C);

    always_comb begin
        w_next  = r_state;
        w_req   = 1'b0;
        w_pcwre = 1'b0;
        case (r_state)
            IDLE: if (w_room) w_next = REQ;
            REQ: begin
                w_req = ~bus.flush;
                if (w_req && bus.imem_gnt) begin
                    w_pcwre = 1'b1;
                    w_next  = WAIT;
                end
            end
            WAIT: begin
                if (bus.flush)            w_next = bus.imem_rvalid ? REQ : DROP;
                else if (bus.imem_rvalid) w_next = w_room ? REQ : IDLE;
            end
            DROP: if (bus.imem_rvalid) w_next = REQ;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_rd     <= '0;
            r_wr     <= '0;
            r_req_pc <= '0;
        end else begin
            r_state <= w_next;
            r_count <= w_cnt_next;
            if (bus.flush) begin
                r_rd <= '0;
                r_wr <= '0;
            end else begin
                if (w_push) r_wr <= r_wr + PTR_W'(1);
                if (w_pop)  r_rd <= r_rd + PTR_W'(1);
            end
            if (w_pcwre) r_req_pc <= bus.curPC;
        end
    end

    // Buffer storage needs no reset: entries are only visible while counted
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_data[r_wr] <= bus.imem_rdata;
            r_pc[r_wr]   <= r_req_pc;
        end
    end

    assign bus.imem_req   = w_req;
    assign bus.imem_addr  = (r_state == REQ) ? bus.curPC : '0;
    assign bus.PCWre      = w_pcwre;
    assign bus.inst_valid = w_valid;
    assign bus.inst       = w_valid ? r_data[r_rd] : '0;
    assign bus.inst_pc    = w_valid ? r_pc[r_rd]   : '0;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: PC-register and memory models around
// the DUT, a scoreboard of expected {pc, inst}, a vector table and corner cases.
module tb_if_fetch_unit;
    logic CLK;
    logic Reset;

    if_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bif ();

    if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(2)) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .bus  (bif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        gnt;
        logic        ready;
        logic        e_req;
        logic        e_pcwre;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int pcwre_cnt, pop_cnt;

    ent_t        q[$];
    logic [31:0] m_pc, m_pend_addr, flush_target;
    logic        m_pend, m_drop, auto_rsp, fixed_data;

    logic        s_req, s_gnt, s_pcwre, s_valid, s_flush, s_rvalid;
    logic [31:0] s_addr, s_inst, s_ipc, s_rdata;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rsp_data(input logic [31:0] a);
        return fixed_data ? 32'h2008_0005 : (a ^ 32'hC0DE_0000);
    endfunction

    // One cycle: sample/check at negedge, update models, drive next inputs after posedge
    task automatic tick();
        ent_t e;
        @(negedge CLK);
        s_req    = bif.imem_req;   s_gnt   = bif.imem_gnt;   s_pcwre = bif.PCWre;
        s_addr   = bif.imem_addr;  s_valid = bif.inst_valid; s_inst  = bif.inst;
        s_ipc    = bif.inst_pc;    s_flush = bif.flush;      s_rvalid = bif.imem_rvalid;
        s_rdata  = bif.imem_rdata;
        if (s_pcwre) pcwre_cnt++;
        chk("sb_valid", s_valid, q.size() != 0);
        if (!s_valid) chk("empty_out", {s_ipc, s_inst}, 64'h0);
        if (s_valid && bif.inst_ready && !s_flush && q.size() != 0) begin
            e = q.pop_front();
            chk("sb_inst", s_inst, e.data);
            chk("sb_pc", s_ipc, e.pc);
            pop_cnt++;
        end
        if (s_req) chk("req_addr", s_addr, m_pc);
        chk("pcwre_gnt", s_pcwre, s_req & s_gnt);
        if (s_flush) q.delete();
        if (s_rvalid && m_pend) begin
            if (!s_flush && !m_drop) q.push_back('{pc: m_pend_addr, data: s_rdata});
            m_pend = 1'b0;
            m_drop = 1'b0;
        end else if (s_flush && m_pend) begin
            m_drop = 1'b1;
        end
        if (s_req && s_gnt) begin
            m_pend      = 1'b1;
            m_pend_addr = m_pc;
        end
        @(posedge CLK);
        #1;
        if (s_flush)      m_pc = flush_target;
        else if (s_pcwre) m_pc = m_pc + 32'd4;
        bif.curPC       = m_pc;
        bif.flush       = 1'b0;
        bif.imem_rvalid = auto_rsp & m_pend;
        bif.imem_rdata  = (auto_rsp && m_pend) ? rsp_data(m_pend_addr) : 32'h0;
    endtask

    task automatic clear_model();
        m_pc = 32'h0; m_pend = 1'b0; m_drop = 1'b0; m_pend_addr = 32'h0;
        q.delete();
        bif.curPC = 32'h0; bif.flush = 1'b0; bif.imem_gnt = 1'b0;
        bif.imem_rvalid = 1'b0; bif.imem_rdata = 32'h0; bif.inst_ready = 1'b0;
        pcwre_cnt = 0; pop_cnt = 0;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        clear_model();
        @(negedge CLK);
        chk("rst_req", bif.imem_req, 0);
        chk("rst_pcwre", bif.PCWre, 0);
        chk("rst_valid", bif.inst_valid, 0);
        chk("rst_inst", {bif.inst_pc, bif.inst}, 64'h0);
        @(posedge CLK);
        #1;
        Reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b0;
        auto_rsp = 1'b1; fixed_data = 1'b1; flush_target = 32'h0;
        // gnt, ready, req, pcwre, valid, inst, pc  (back-to-back fetch, decode always ready)
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h2008_0005, 32'h0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h2008_0005, 32'h4};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h2008_0005, 32'h8};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            bif.imem_gnt   = tbl[i].gnt;
            bif.inst_ready = tbl[i].ready;
            tick();
            chk("tbl_req",   s_req,   tbl[i].e_req);
            chk("tbl_pcwre", s_pcwre, tbl[i].e_pcwre);
            chk("tbl_valid", s_valid, tbl[i].e_valid);
            chk("tbl_inst",  s_inst,  tbl[i].e_inst);
            chk("tbl_pc",    s_ipc,   tbl[i].e_pc);
        end

        // Decode stalled: two fetches fill the buffer, then fetch parks in IDLE
        fixed_data = 1'b0;
        do_reset();
        bif.imem_gnt = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i >= 6) chk("t2_idle_req", s_req, 0);
        end
        chk("t2_pushes", pcwre_cnt, 2);
        chk("t2_head_pc", s_ipc, 32'h0);
        bif.inst_ready = 1'b1;
        tick();
        chk("t2_pop0", s_ipc, 32'h0);
        tick();
        chk("t2_pop1", s_ipc, 32'h4);
        for (int i = 0; i < 6; i++) tick();
        chk("t2_resume", pcwre_cnt > 2, 1);
        chk("t2_pops", pop_cnt >= 2, 1);

        // Grant withheld for three cycles in REQ
        do_reset();
        bif.inst_ready = 1'b1;
        tick();
        chk("t3_idle", s_req, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_req_hold", s_req, 1);
            chk("t3_addr_hold", s_addr, 32'h0);
            chk("t3_no_pcwre", s_pcwre, 0);
        end
        bif.imem_gnt = 1'b1;
        tick();
        chk("t3_pcwre_gnt", s_pcwre, 1);
        chk("t3_addr_gnt", s_addr, 32'h0);
        for (int i = 0; i < 4; i++) tick();

        // Flush while waiting; late response must be dropped
        do_reset();
        auto_rsp = 1'b0;
        bif.imem_gnt = 1'b1; bif.inst_ready = 1'b1;
        tick();
        tick();
        chk("t4_grant", s_pcwre, 1);
        flush_target = 32'h40;
        bif.flush = 1'b1;
        tick();
        chk("t4_wait_req", s_req, 0);
        tick();
        chk("t4_drop_req", s_req, 0);
        bif.imem_rvalid = 1'b1;
        bif.imem_rdata  = 32'hDEAD_BEEF;
        tick();
        chk("t4_drop_rsp", s_req, 0);
        auto_rsp = 1'b1;
        tick();
        chk("t4_redirect_req", s_req, 1);
        chk("t4_redirect_addr", s_addr, 32'h40);
        chk("t4_empty", s_valid, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t4_no_stale", s_inst == 32'hDEAD_BEEF, 0);
        end

        // Flush coincident with rvalid while one entry is buffered and decode ready
        do_reset();
        bif.imem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("t5_pre_valid", s_valid, 1);
        bif.inst_ready = 1'b1;
        flush_target   = 32'h80;
        bif.flush      = 1'b1;
        tick();
        chk("t5_flush_rvalid", s_rvalid, 1);
        tick();
        chk("t5_cleared", s_valid, 0);
        chk("t5_req", s_req, 1);
        chk("t5_addr", s_addr, 32'h80);
        for (int i = 0; i < 4; i++) tick();

        // Asynchronous reset between edges while waiting with a buffered entry
        do_reset();
        bif.imem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("t6_pre_valid", s_valid, 1);
        #2;
        Reset = 1'b0;
        bif.imem_rvalid = 1'b0;
        #1;
        chk("t6_async_valid", bif.inst_valid, 0);
        chk("t6_async_out", {bif.inst_pc, bif.inst}, 64'h0);
        chk("t6_async_req", {bif.imem_req, bif.PCWre}, 0);
        clear_model();
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        bif.imem_gnt = 1'b1;
        tick();
        chk("t6_idle", s_req, 0);
        tick();
        chk("t6_first_req", s_req, 1);
        chk("t6_first_addr", s_addr, 32'h0);
        for (int i = 0; i < 3; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
